// File: rtl/ctrl_sequencer.sv
// Microcoded T-state sequencer for the 8-bit accumulator CPU: steps fetch/execute
// stages on the falling clock edge and decodes the opcode into the datapath control word.
module ctrl_sequencer #(
   parameter int OPCODE_W    = 4,
   parameter int STAGE_W     = 3,
   parameter int SKIP_IDLE   = 1,
   parameter int INSTR_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [OPCODE_W-1:0]    opcode,
   input  logic                   flag_c,
   input  logic                   flag_z,
   input  logic                   step_en,
   input  logic                   step,
   output logic [15:0]            ctrl,
   output logic [STAGE_W-1:0]     stage,
   output logic                   halted,
   output logic [INSTR_CNT_W-1:0] instr_cnt
);

   localparam logic [15:0] C_HLT        = 16'h8000;
   localparam logic [15:0] C_PC_INC     = 16'h4000;
   localparam logic [15:0] C_PC_EN      = 16'h2000;
   localparam logic [15:0] C_PC_LOAD    = 16'h1000;
   localparam logic [15:0] C_MAR_LOAD   = 16'h0800;
   localparam logic [15:0] C_MEM_ST     = 16'h0400;
   localparam logic [15:0] C_MEM_EN     = 16'h0200;
   localparam logic [15:0] C_IR_LOAD    = 16'h0100;
   localparam logic [15:0] C_IR_EN      = 16'h0080;
   localparam logic [15:0] C_A_LOAD     = 16'h0040;
   localparam logic [15:0] C_A_EN       = 16'h0020;
   localparam logic [15:0] C_B_LOAD     = 16'h0010;
   localparam logic [15:0] C_ALU_SUB    = 16'h0008;
   localparam logic [15:0] C_ALU_EN     = 16'h0004;
   localparam logic [15:0] C_FLAGS_LOAD = 16'h0002;
   localparam logic [15:0] C_OUT_LOAD   = 16'h0001;

   localparam logic [3:0] OP_LDA = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_STA = 4'd3;
   localparam logic [3:0] OP_LDI = 4'd4;
   localparam logic [3:0] OP_JMP = 4'd5;
   localparam logic [3:0] OP_JC  = 4'd6;
   localparam logic [3:0] OP_JZ  = 4'd7;
   localparam logic [3:0] OP_NOP = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   typedef enum logic [2:0] {
      S_T0   = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_HALT = 3'd7
   } state_t;

   state_t                 r_state;
   logic                   r_halted;
   logic [INSTR_CNT_W-1:0] r_instr_cnt;

   logic                   w_ext;
   logic [3:0]             w_op;
   state_t                 w_last;
   logic [15:0]            w_ctrl;

   // Any opcode bit above the 4-bit ISA field turns the instruction into a NOP.
   generate
      if (OPCODE_W > 4) begin : g_ext
         assign w_ext = |opcode[OPCODE_W-1:4];
      end else begin : g_no_ext
         assign w_ext = 1'b0;
      end
   endgenerate

   assign w_op = w_ext ? OP_NOP : opcode[3:0];

   always_comb begin
      case (w_op)
         OP_LDA, OP_STA: w_last = S_T4;
         OP_ADD, OP_SUB: w_last = S_T5;
         default:        w_last = S_T3;
      endcase
   end

   always_comb begin
      w_ctrl = 16'h0000;
      case (r_state)
         S_T0: w_ctrl = C_PC_EN | C_MAR_LOAD;
         S_T1: w_ctrl = C_PC_INC;
         S_T2: w_ctrl = C_MEM_EN | C_IR_LOAD;
         S_T3: begin
            case (w_op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: w_ctrl = C_IR_EN | C_MAR_LOAD;
               OP_LDI: w_ctrl = C_IR_EN | C_A_LOAD;
               OP_JMP: w_ctrl = C_IR_EN | C_PC_LOAD;
               OP_JC:  w_ctrl = flag_c ? (C_IR_EN | C_PC_LOAD) : 16'h0000;
               OP_JZ:  w_ctrl = flag_z ? (C_IR_EN | C_PC_LOAD) : 16'h0000;
               OP_OUT: w_ctrl = C_A_EN | C_OUT_LOAD;
               OP_HLT: w_ctrl = C_HLT;
               default: w_ctrl = 16'h0000;
            endcase
         end
         S_T4: begin
            case (w_op)
               OP_LDA:         w_ctrl = C_MEM_EN | C_A_LOAD;
               OP_ADD, OP_SUB: w_ctrl = C_MEM_EN | C_B_LOAD;
               OP_STA:         w_ctrl = C_A_EN | C_MEM_ST;
               default:        w_ctrl = 16'h0000;
            endcase
         end
         S_T5: begin
            case (w_op)
               OP_ADD:  w_ctrl = C_ALU_EN | C_A_LOAD | C_FLAGS_LOAD;
               OP_SUB:  w_ctrl = C_ALU_SUB | C_ALU_EN | C_A_LOAD | C_FLAGS_LOAD;
               default: w_ctrl = 16'h0000;
            endcase
         end
         S_HALT:  w_ctrl = C_HLT;
         default: w_ctrl = 16'h0000;
      endcase
   end

   // Falling-edge state so the datapath sees a settled control word at its rising edge.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_T0;
         r_halted    <= 1'b0;
         r_instr_cnt <= '0;
      end else begin
         case (r_state)
            S_T0: begin
               if (!step_en || step) begin
                  r_state <= S_T1;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               if (r_state == S_T3 && w_op == OP_HLT) begin
                  r_state     <= S_HALT;
                  r_halted    <= 1'b1;
                  r_instr_cnt <= r_instr_cnt + INSTR_CNT_W'(1);
               end else if (r_state == S_T5 || (SKIP_IDLE != 0 && r_state == w_last)) begin
                  r_state     <= S_T0;
                  r_instr_cnt <= r_instr_cnt + INSTR_CNT_W'(1);
               end else begin
                  r_state <= state_t'(r_state + 3'd1);
               end
            end
         endcase
      end
   end

   assign ctrl      = rst ? 16'h0000 : w_ctrl;
   assign stage     = STAGE_W'(r_state);
   assign halted    = r_halted;
   assign instr_cnt = r_instr_cnt;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Parametrised microcoded control sequencer for the 8-bit accumulator CPU. It steps through fetch/execute T-states and decodes the opcode into a 16-bit control word for the PC, MAR, RAM, IR, A, B, ALU, flags and output register. It supports a variable-length instruction mode, conditional jumps, a sticky halt state, single-step operation and a retired-instruction counter. It sits between the IR opcode field and the datapath enables.

Parameters:
OPCODE_W, 4, opcode width (>=4); opcodes with any bit above bit 3 set decode as NOP
STAGE_W, 3, width of stage output (>=3)
SKIP_IDLE, 1, 1: instruction ends after its last active stage; 0: every instruction runs T0..T5
INSTR_CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock; sequencer state changes on negedge
rst  in  1  reset, asynchronous, active-high
opcode  in  OPCODE_W  IR opcode field, stable from end of T2
flag_c  in  1  carry flag from flags register
flag_z  in  1  zero flag from flags register
step_en  in  1  1 = single-step mode
step  in  1  advance request in single-step mode, sampled on negedge
ctrl  out  16  control word [15]hlt [14]pc_inc [13]pc_en [12]pc_load [11]mar_load [10]mem_st [9]mem_en [8]ir_load [7]ir_en [6]a_load [5]a_en [4]b_load [3]alu_sub [2]alu_en [1]flags_load [0]out_load
stage  out  STAGE_W  current T-state 0..5; 7 in HALT
halted  out  1  high in HALT state
instr_cnt  out  INSTR_CNT_W  retired instructions, wraps

Behaviour:
- Reset: stage=0, halted=0, instr_cnt=0. ctrl forced to 0 while rst is high. Reset mid-instruction or in HALT aborts immediately.
- ctrl is combinational from stage, opcode and flags. All state advances on negedge clk so the datapath sees stable ctrl at posedge.
- Fetch, all opcodes: T0 = pc_en|mar_load (0x2800); T1 = pc_inc (0x4000); T2 = mem_en|ir_load (0x0300).
- Execute (T3 / T4 / T5, length in stages):
  - LDA=0: ir_en|mar_load / mem_en|a_load; length 5.
  - ADD=1: ir_en|mar_load / mem_en|b_load / alu_en|a_load|flags_load; length 6.
  - SUB=2: as ADD, with alu_sub also set in T5; length 6.
  - STA=3: ir_en|mar_load / a_en|mem_st; length 5.
  - LDI=4: ir_en|a_load; length 4.
  - JMP=5: ir_en|pc_load; length 4.
  - JC=6: ir_en|pc_load only if flag_c=1, else 0; length 4.
  - JZ=7: same as JC using flag_z; length 4.
  - OUT=14: a_en|out_load; length 4.
  - HLT=15: hlt in T3.
  - 8..13 and extended opcodes: NOP, ctrl=0 in T3; length 4.
- SKIP_IDLE=1: after the last stage of the instruction's length, the next negedge goes to T0. SKIP_IDLE=0: always T5→T0; unused stages output ctrl=0.
- JC/JZ flags are sampled during T3 (combinational). flags_load in ADD/SUB T5 affects only the following instruction.
- HLT: at the negedge ending T3, enter HALT. In HALT: ctrl=0x8000, stage=7, halted=1, opcode ignored. Only rst exits HALT.
- Single step: in T0, the advance to T1 happens only if step_en=0 or step=1 at that negedge. Otherwise the sequencer holds T0 with ctrl=0x2800. Stages T1..T5 never stall. A level-held step advances one instruction per T0 visit.
- instr_cnt increments by 1 on every negedge that completes an instruction (last stage→T0, or T3→HALT). It wraps from 2^INSTR_CNT_W−1 to 0.
- Toggling step_en mid-instruction affects only the next T0.

Test Plan:
- Reset then LDA, SKIP_IDLE=1 → ctrl sequence 0x2800,0x4000,0x0300,0x0880,0x0240, then back to T0; instr_cnt=1.
- SUB with SKIP_IDLE=0 → T5 ctrl=0x004E (alu_sub|alu_en|a_load|flags_load). Then LDI: T4,T5 ctrl=0, then T0.
- JZ with flag_z=0 → T3 ctrl=0x0000, 4 stages. JZ with flag_z=1 → T3 ctrl=0x1080.
- HLT → T3 ctrl=0x8000. Next negedge: halted=1, stage=7, ctrl=0x8000 held for 20 cycles, instr_cnt incremented once. Assert rst → stage=0, halted=0, ctrl=0.
- step_en=1, step=0 for 10 cycles → stage stays 0, instr_cnt unchanged. One-cycle step pulse → exactly one instruction runs, then T0 holds.
- INSTR_CNT_W=4, run 17 NOPs → instr_cnt=1. Assert rst during T4 of ADD → outputs at reset values immediately, without waiting for a clock edge.
